// File: rtl/select_encode_ctrl.sv
// select_encode_ctrl
// Register-select decoder and bus-transfer sequencer. Captures the
// instruction register from the shared bus and turns its Ra/Rb/Rc fields
// into one-hot load/drive enables for the 16-entry register file. It also
// produces the sign-extended constant. A small FSM runs register-to-register
// moves over the bus: DRIVE puts the source on the bus, LATCH also loads the
// destination, and DONE reports completion.
module select_encode_ctrl (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] BusMuxOut,
  input  logic        IRin,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        mv_start,
  input  logic [1:0]  mv_src,
  input  logic [1:0]  mv_dst,
  output logic [31:0] IR,
  output logic [4:0]  opcode,
  output logic [15:0] R_in,
  output logic [15:0] R_out,
  output logic        ba_zero,
  output logic [31:0] C_sign_extended,
  output logic        mv_busy,
  output logic        mv_done,
  output logic        mv_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [3:0] src_idx;
  logic [3:0] dst_idx;

  // IR fields
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;

  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];

  assign opcode          = IR[31:27];
  assign C_sign_extended = {{13{IR[18]}}, IR[18:0]};

  // The sequencer only accepts new work (and IR loads) when it is not
  // holding the select outputs.
  logic accepting;
  logic codes_legal;

  assign accepting   = (state == IDLE) || (state == DONE);
  assign codes_legal = (mv_src != 2'b00) && (mv_dst != 2'b00);

  assign mv_busy = (state == DRIVE) || (state == LATCH);
  assign mv_done = (state == DONE);

  // Map a 2-bit field code to the register index held in that IR field.
  // Code 00 never reaches here for a move, so it maps to Rc as a don't-care.
  function automatic logic [3:0] field_index(input logic [1:0] code,
                                             input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] c);
    case (code)
      2'b01:   field_index = a;
      2'b10:   field_index = b;
      default: field_index = c;
    endcase
  endfunction

  // State, IR and move-index registers with synchronous clear.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      IR      <= '0;
      src_idx <= '0;
      dst_idx <= '0;
      mv_err  <= 1'b0;
    end else begin
      mv_err <= accepting && mv_start && !codes_legal;

      if (accepting && IRin) begin
        IR <= BusMuxOut;
      end

      case (state)
        IDLE, DONE: begin
          if (mv_start && codes_legal) begin
            // Indices are frozen here so later IR loads cannot disturb
            // an in-flight move.
            src_idx <= field_index(mv_src, ra, rb, rc);
            dst_idx <= field_index(mv_dst, ra, rb, rc);
            state   <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE:   state <= LATCH;
        LATCH:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Manual field selection, priority Gra > Grb > Grc.
  logic [3:0] sel;
  logic       sel_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    sel       = 4'd0;
    sel_valid = 1'b0;
    if (Gra) begin
      sel       = ra;
      sel_valid = 1'b1;
    end else if (Grb) begin
      sel       = rb;
      sel_valid = 1'b1;
    end else if (Grc) begin
      sel       = rc;
      sel_valid = 1'b1;
    end
  end

  // Select outputs: the sequencer owns them in DRIVE/LATCH, manual strobes
  // drive them in IDLE/DONE. BAout with R0 selected forces a zero on the bus
  // instead of driving R0.
  always_comb begin
    R_in    = '0;
    R_out   = '0;
    ba_zero = 1'b0;
    case (state)
      DRIVE: begin
        R_out = 16'h0001 << src_idx;
      end
      LATCH: begin
        R_out = 16'h0001 << src_idx;
        R_in  = 16'h0001 << dst_idx;
      end
      default: begin
        if (sel_valid) begin
          if (Rin) begin
            R_in = 16'h0001 << sel;
          end
          if (BAout && (sel == 4'd0)) begin
            ba_zero = 1'b1;
          end else if (Rout || BAout) begin
            R_out = 16'h0001 << sel;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_select_encode_ctrl.sv
// tb_select_encode_ctrl
// Directed-vector bench with a scoreboard: the stimulus process pushes the
// hand-computed expected outputs for each cycle into a queue, and a monitor
// on the falling edge pops and compares them against the DUT.
module tb_select_encode_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        IRin, Gra, Grb, Grc, Rin, Rout, BAout, mv_start;
  logic [1:0]  mv_src, mv_dst;
  logic [31:0] IR;
  logic [4:0]  opcode;
  logic [15:0] R_in, R_out;
  logic        ba_zero;
  logic [31:0] C_sign_extended;
  logic        mv_busy, mv_done, mv_err;

  select_encode_ctrl dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .mv_start(mv_start), .mv_src(mv_src), .mv_dst(mv_dst),
    .IR(IR), .opcode(opcode), .R_in(R_in), .R_out(R_out), .ba_zero(ba_zero),
    .C_sign_extended(C_sign_extended), .mv_busy(mv_busy), .mv_done(mv_done),
    .mv_err(mv_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] ir;
    logic [4:0]  op;
    logic [31:0] c;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        ba;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // Current hand-computed IR-derived expectations, set by the stimulus.
  logic [31:0] exp_ir = 32'h0;
  logic [4:0]  exp_op = 5'h0;
  logic [31:0] exp_c  = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic push(input string name, input logic [15:0] rin,
                      input logic [15:0] rout, input logic ba,
                      input logic busy, input logic done, input logic err);
    exp_t e;
    e.name = name; e.cyc = cyc;
    e.ir = exp_ir; e.op = exp_op; e.c = exp_c;
    e.r_in = rin; e.r_out = rout; e.ba = ba;
    e.busy = busy; e.done = done; e.err = err;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ir, input logic [4:0] op,
                        input logic [31:0] c);
    exp_ir = ir; exp_op = op; exp_c = c;
  endtask

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        check({e.name, ".stale"}, 32'(e.cyc), 32'(cyc));
      end else begin
        check({e.name, ".IR"},     IR,                 e.ir);
        check({e.name, ".opcode"}, 32'(opcode),        32'(e.op));
        check({e.name, ".C"},      C_sign_extended,    e.c);
        check({e.name, ".R_in"},   32'(R_in),          32'(e.r_in));
        check({e.name, ".R_out"},  32'(R_out),         32'(e.r_out));
        check({e.name, ".ba_zero"}, 32'(ba_zero),      32'(e.ba));
        check({e.name, ".mv_busy"}, 32'(mv_busy),      32'(e.busy));
        check({e.name, ".mv_done"}, 32'(mv_done),      32'(e.done));
        check({e.name, ".mv_err"},  32'(mv_err),       32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; BusMuxOut = '0; IRin = 0; Gra = 0; Grb = 0; Grc = 0;
    Rin = 0; Rout = 0; BAout = 0; mv_start = 0; mv_src = 0; mv_dst = 0;

    // Reset: two clear edges, no strobes.
    step(); step();
    clear = 1'b0;
    push("reset", 16'h0, 16'h0, 0, 0, 0, 0);

    // IR load and field decode.
    BusMuxOut = 32'h11ABFFFF; IRin = 1;
    step();
    IRin = 0;
    set_ir(32'h11ABFFFF, 5'h02, 32'h0003FFFF);
    push("ir_load", 16'h0, 16'h0, 0, 0, 0, 0);
    step();
    Grb = 1; Rin = 1;
    push("grb_rin", 16'h0020, 16'h0, 0, 0, 0, 0);
    step();
    Grb = 0; Rin = 0; Grc = 1; Rout = 1;
    push("grc_rout", 16'h0, 16'h0080, 0, 0, 0, 0);
    step();
    Grc = 0; Rout = 0;

    // Sign extension with IR[18]=1.
    BusMuxOut = 32'h00040000; IRin = 1;
    step();
    IRin = 0;
    set_ir(32'h00040000, 5'h00, 32'hFFFC0000);
    push("sign_ext", 16'h0, 16'h0, 0, 0, 0, 0);

    // BAout with R0 selected.
    BusMuxOut = 32'h00000000; IRin = 1;
    step();
    IRin = 0; Gra = 1; BAout = 1;
    set_ir(32'h0, 5'h0, 32'h0);
    push("ba_r0", 16'h0, 16'h0, 1, 0, 0, 0);
    step();
    Gra = 0; BAout = 0;

    // BAout with Ra=3.
    BusMuxOut = 32'h01800000; IRin = 1;
    step();
    IRin = 0; Gra = 1; BAout = 1;
    set_ir(32'h01800000, 5'h0, 32'h0);
    push("ba_r3", 16'h0, 16'h0008, 0, 0, 0, 0);
    step();
    Gra = 0; BAout = 0;

    // Move Ra(3) -> Rc(7); manual strobes and IRin during the move are ignored.
    BusMuxOut = 32'h11ABFFFF; IRin = 1;
    step();
    IRin = 0;
    set_ir(32'h11ABFFFF, 5'h02, 32'h0003FFFF);
    mv_start = 1; mv_src = 2'b01; mv_dst = 2'b11;
    push("mv1_start", 16'h0, 16'h0, 0, 0, 0, 0);
    step();
    mv_start = 0; Gra = 1; Rin = 1; IRin = 1; BusMuxOut = 32'hFFFFFFFF;
    push("mv1_drive", 16'h0, 16'h0008, 0, 1, 0, 0);
    step();
    push("mv1_latch", 16'h0080, 16'h0008, 0, 1, 0, 0);
    step();
    Gra = 0; Rin = 0; IRin = 0;
    // Held start in DONE: back-to-back self-reload Rb(5) -> Rb(5).
    mv_start = 1; mv_src = 2'b10; mv_dst = 2'b10;
    push("mv1_done", 16'h0, 16'h0, 0, 0, 1, 0);
    step();
    push("mv2_drive", 16'h0, 16'h0020, 0, 1, 0, 0);
    step();
    mv_start = 0;
    push("mv2_latch", 16'h0020, 16'h0020, 0, 1, 0, 0);
    step();
    push("mv2_done", 16'h0, 16'h0, 0, 0, 1, 0);
    step();
    push("mv2_idle", 16'h0, 16'h0, 0, 0, 0, 0);

    // Illegal source code.
    mv_start = 1; mv_src = 2'b00; mv_dst = 2'b01;
    step();
    mv_start = 0;
    push("err_pulse", 16'h0, 16'h0, 0, 0, 0, 1);
    step();
    push("err_clear", 16'h0, 16'h0, 0, 0, 0, 0);

    // Clear during LATCH aborts the move and beats IRin.
    mv_start = 1; mv_src = 2'b01; mv_dst = 2'b11;
    step();
    mv_start = 0;
    push("ab_drive", 16'h0, 16'h0008, 0, 1, 0, 0);
    step();
    clear = 1; IRin = 1; BusMuxOut = 32'hDEADBEEF;
    push("ab_latch", 16'h0080, 16'h0008, 0, 1, 0, 0);
    step();
    clear = 0; IRin = 0;
    set_ir(32'h0, 5'h0, 32'h0);
    push("ab_idle", 16'h0, 16'h0, 0, 0, 0, 0);
    step();
    push("ab_no_done", 16'h0, 16'h0, 0, 0, 0, 0);

    step(); step();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
